// File: rtl/vTPU_pack.sv
// ----------------------------------------------------------------------------
// vTPU_pack
// Shared types and constants for the vegeta instruction path.
//   WORD_TYPE         32-bit instruction segment (lower / middle)
//   HALFWORD_TYPE     16-bit instruction segment (upper)
//   INSTRUCTION_TYPE  full 80-bit instruction {upper, middle, lower}
//   SEGMENT_COUNT     number of segments that make up one instruction
// ----------------------------------------------------------------------------
package vTPU_pack;

  typedef logic [31:0] WORD_TYPE;
  typedef logic [15:0] HALFWORD_TYPE;
  typedef logic [79:0] INSTRUCTION_TYPE;

  localparam int SEGMENT_COUNT = 3;

  // Segment positions inside the write_en strobe vector.
  localparam int SEG_LOWER  = 0;
  localparam int SEG_MIDDLE = 1;
  localparam int SEG_UPPER  = 2;

  // Concatenate the three segments into one instruction word.
  function automatic INSTRUCTION_TYPE assemble_instr(input WORD_TYPE     lower,
                                                     input WORD_TYPE     middle,
                                                     input HALFWORD_TYPE upper);
    return {upper, middle, lower};
  endfunction

endpackage : vTPU_pack

// File: rtl/vegeta_instr_assembler.sv
// ----------------------------------------------------------------------------
// vegeta_instr_assembler
// Collects the three instruction segments, which may arrive in any order and
// in any cycles, and signals completion once all three have been seen.
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (clears the segment mask)
//   lower_word   segment bits [31:0]
//   middle_word  segment bits [63:32]
//   upper_word   segment bits [79:64]
//   write_en     per-segment strobes {lower, middle, upper}
//   flush        drop any partially collected instruction
//   complete     all segments present this cycle (mask | write_en == 111)
//   instr        assembled instruction, valid while complete is high
// ----------------------------------------------------------------------------
module vegeta_instr_assembler
  import vTPU_pack::*;
(
  input  logic            clk,
  input  logic            rst,
  input  WORD_TYPE        lower_word,
  input  WORD_TYPE        middle_word,
  input  HALFWORD_TYPE    upper_word,
  input  logic            write_en [0:SEGMENT_COUNT-1],
  input  logic            flush,
  output logic            complete,
  output INSTRUCTION_TYPE instr
);

  logic [SEGMENT_COUNT-1:0] we_vec;
  logic [SEGMENT_COUNT-1:0] mask_reg;
  logic [SEGMENT_COUNT-1:0] mask_next;

  WORD_TYPE     lower_reg;
  WORD_TYPE     middle_reg;
  HALFWORD_TYPE upper_reg;

  WORD_TYPE     lower_sel;
  WORD_TYPE     middle_sel;
  HALFWORD_TYPE upper_sel;

  // Strobes are suppressed during flush so nothing written in that cycle
  // survives into the next instruction.
  genvar gi;
  generate
    for (gi = 0; gi < SEGMENT_COUNT; gi++) begin : g_seg_we
      assign we_vec[gi] = write_en[gi] && !flush;
    end
  endgenerate

  always_comb begin
    // A segment written in the completing cycle bypasses the staging register.
    lower_sel  = we_vec[SEG_LOWER]  ? lower_word  : lower_reg;
    middle_sel = we_vec[SEG_MIDDLE] ? middle_word : middle_reg;
    upper_sel  = we_vec[SEG_UPPER]  ? upper_word  : upper_reg;

    complete  = !flush && ((mask_reg | we_vec) == '1);
    instr     = assemble_instr(lower_sel, middle_sel, upper_sel);

    mask_next = mask_reg | we_vec;
    if (flush || complete) begin
      mask_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask_reg <= '0;
    end else begin
      mask_reg <= mask_next;
    end
  end

  // Segment data is qualified by the mask, so it needs no reset.
  always_ff @(posedge clk) begin
    if (we_vec[SEG_LOWER]) begin
      lower_reg <= lower_word;
    end
    if (we_vec[SEG_MIDDLE]) begin
      middle_reg <= middle_word;
    end
    if (we_vec[SEG_UPPER]) begin
      upper_reg <= upper_word;
    end
  end

endmodule : vegeta_instr_assembler

// File: rtl/vegeta_instr_queue.sv
// ----------------------------------------------------------------------------
// vegeta_instr_queue
// First-word-fall-through queue of 80-bit instructions fed by a segment
// assembler and drained by the tpu_core.
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   lower_word    instruction bits [31:0]
//   middle_word   instruction bits [63:32]
//   upper_word    instruction bits [79:64]
//   write_en      per-segment write strobes {lower, middle, upper}
//   flush         discard all queued and partially assembled instructions
//   clear_errors  clear sticky overflow / underflow
//   instr_out     head-of-queue instruction
//   instr_valid   instr_out is valid (queue not empty)
//   instr_ready   consumer takes the head this cycle
//   empty/full/almost_full  occupancy status
//   count         current occupancy
//   overflow      sticky: completed instruction dropped because queue full
//   underflow     sticky: instr_ready seen while empty
// ----------------------------------------------------------------------------
module vegeta_instr_queue
  import vTPU_pack::*;
#(
  parameter int DEPTH             = 32,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  WORD_TYPE                   lower_word,
  input  WORD_TYPE                   middle_word,
  input  HALFWORD_TYPE               upper_word,
  input  logic                       write_en [0:SEGMENT_COUNT-1],
  input  logic                       flush,
  input  logic                       clear_errors,
  output INSTRUCTION_TYPE            instr_out,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL    = CW'(ALMOST_FULL_LEVEL);

  INSTRUCTION_TYPE mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg,  count_next;
  logic          overflow_reg,  overflow_next;
  logic          underflow_reg, underflow_next;

  logic            complete;
  INSTRUCTION_TYPE assembled;

  logic push;
  logic pop;
  logic overflow_event;
  logic underflow_event;

  vegeta_instr_assembler u_assembler (
    .clk         (clk),
    .rst         (rst),
    .lower_word  (lower_word),
    .middle_word (middle_word),
    .upper_word  (upper_word),
    .write_en    (write_en),
    .flush       (flush),
    .complete    (complete),
    .instr       (assembled)
  );

  // Status flags depend on the count register only.
  assign empty       = (count_reg == '0);
  assign full        = (count_reg == DEPTH_LEVEL);
  assign almost_full = (count_reg >= AF_LEVEL);
  assign count       = count_reg;
  assign instr_valid = !empty;
  assign instr_out   = mem[rd_ptr_reg];
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  always_comb begin
    // complete is already gated by flush inside the assembler. A pop frees a
    // slot in the same cycle, so a full queue can still accept a completion.
    pop             = instr_valid && instr_ready && !flush;
    underflow_event = empty && instr_ready && !flush;
    push            = complete && (!full || pop);
    overflow_event  = complete && full && !pop;

    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      if (push && !pop) begin
        count_next = count_reg + CW'(1);
      end else if (pop && !push) begin
        count_next = count_reg - CW'(1);
      end
    end

    // A new error event in the clearing cycle keeps the flag set.
    if (overflow_event) begin
      overflow_next = 1'b1;
    end else if (clear_errors) begin
      overflow_next = 1'b0;
    end

    if (underflow_event) begin
      underflow_next = 1'b1;
    end else if (clear_errors) begin
      underflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage is not reset; occupancy tracking decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= assembled;
    end
  end

endmodule : vegeta_instr_queue
